// File: rtl/forward_sel_unit_pkg.sv
// Shared operand-forwarding definitions: mux select encodings, the
// destination-register slot record and the producer test.
package forward_sel_unit_pkg;

    localparam int unsigned RF_IDX_W = 5;

    // Select encodings for the EX-stage 3-to-1 operand muxes
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam logic [RF_IDX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [RF_IDX_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic is_producer(input slot_t s);
        return s.valid & s.reg_write & (s.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/forward_sel_unit_cmp.sv
// Per-source comparator: picks the forwarding select for one ID source
// and flags a hit on a load still sitting in EX.
module fwd_src_cmp
    import forward_sel_unit_pkg::*;
(
    input  logic [RF_IDX_W-1:0] src_i,
    input  logic                use_i,
    input  slot_t               ex_i,
    input  slot_t               mem_i,
    output fwd_sel_e            sel_o,
    output logic                load_hit_o
);

    logic ex_match;
    logic mem_match;
    logic mem_unused;

    assign ex_match   = use_i & is_producer(ex_i)  & (ex_i.rd  == src_i);
    assign mem_match  = use_i & is_producer(mem_i) & (mem_i.rd == src_i);
    assign load_hit_o = ex_match & ex_i.mem_read;
    assign mem_unused = mem_i.mem_read;

    // EX wins over MEM: the youngest producer holds the live value
    always_comb begin
        sel_o = FWD_RF;
        if (ex_match) begin
            sel_o = FWD_EXMEM;
        end else if (mem_match) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_sel_unit.sv
// EX operand forwarding select and load-use stall generation, with a
// shadow EX/MEM/WB pipeline of destination-register info.
module forward_sel_unit
    import forward_sel_unit_pkg::*;
#(
    parameter int unsigned REG_W = 5,   // must equal RF_IDX_W
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            ex_q, ex_d, mem_q, wb_q;
    fwd_sel_e         sel_a_d, sel_b_d, sel_a_q, sel_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit_a, hit_b;
    logic             bubble;
    logic             wb_unused;

    fwd_src_cmp u_cmp_a (
        .src_i      (id_rs),
        .use_i      (id_uses_rs),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_a_d),
        .load_hit_o (hit_a)
    );

    fwd_src_cmp u_cmp_b (
        .src_i      (id_rt),
        .use_i      (id_uses_rt),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_b_d),
        .load_hit_o (hit_b)
    );

    assign stall  = id_valid & ~flush & (hit_a | hit_b);
    assign bubble = flush | stall;

    always_comb begin
        ex_d           = SLOT_EMPTY;
        ex_d.valid     = id_valid;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        if (bubble) begin
            ex_d = SLOT_EMPTY;
        end
    end

    // WB is kept for visibility only; the register file covers it
    assign wb_unused = ^wb_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            wb_q    <= SLOT_EMPTY;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            sel_a_q <= bubble ? FWD_RF : sel_a_d;
            sel_b_q <= bubble ? FWD_RF : sel_b_d;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid  = ex_q.valid;
    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_sel_unit.sv
// Scoreboard bench for forward_sel_unit: instruction sequences with
// hand-derived selects, stall and counter expectations.
module tb_forward_sel_unit;

    localparam int unsigned CW = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic [4:0]    id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic          ex_valid;
    logic [1:0]    fwd_sel_a;
    logic [1:0]    fwd_sel_b;
    logic [CW-1:0] stall_cnt;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [4:0]    exp_q[$];

    forward_sel_unit #(.REG_W(5), .CNT_W(CW)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_cnt    (stall_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl,
                         input logic exp_st, input logic exp_ev,
                         input logic [1:0] exp_a, input logic [1:0] exp_b);
        logic [4:0] e;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
        check("stall", stall, exp_st);
        exp_q.push_back({exp_ev, exp_a, exp_b});
        if (exp_st && (exp_cnt != '1)) exp_cnt++;
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check("ex_valid", ex_valid, e[4]);
        check("sel_a", fwd_sel_a, e[3:2]);
        check("sel_b", fwd_sel_b, e[1:0]);
        check("stall_cnt", stall_cnt, exp_cnt);
    endtask

    task automatic nop2();
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        // reset held with random ID activity
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            {id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush} = 6'($urandom);
            id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
            #1;
            check("rst_stall", stall, 0);
            check("rst_ex_valid", ex_valid, 0);
            check("rst_sel_a", fwd_sel_a, 0);
            check("rst_sel_b", fwd_sel_b, 0);
            check("rst_cnt", stall_cnt, 0);
        end
        id_valid = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1;

        // first instruction after reset, rs=5
        drive(1, 5, 6, 1, 1, 5, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        nop2();

        // add $3 ; sub $4,$3,$2
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 1, 2'b01, 2'b00);
        nop2();

        // add $3 ; nop ; or $5,$3,$3
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(1, 3, 3, 1, 1, 5, 1, 0, 0, 0, 1, 2'b10, 2'b10);
        nop2();

        // add $3 ; add $3,$3,$1 ; and $6,$3,$0
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 3, 1, 1, 1, 3, 1, 0, 0, 0, 1, 2'b01, 2'b00);
        drive(1, 3, 0, 1, 1, 6, 1, 0, 0, 0, 1, 2'b01, 2'b00);
        nop2();

        // lw $7 ; add $8,$7,$1 -> one stall, then MEM/WB forward
        drive(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 2'b00, 2'b00);
        drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 1, 2'b10, 2'b00);
        nop2();

        // register zero: add $0 ; add $9,$0,$0
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        nop2();
        // lw $0 ; use of $0 -> no stall
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        nop2();
        // matching rt with id_uses_rt = 0
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 1, 3, 1, 0, 11, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        nop2();

        // flush coincident with load-use
        drive(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 7, 1, 1, 1, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        nop2();

        // chained dependent loads drive the counter to saturation
        drive(1, 2, 0, 1, 0, 7, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            drive(1, 7, 0, 1, 0, 7, 1, 1, 0, 1, 0, 2'b00, 2'b00);
            drive(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 1, 2'b10, 2'b00);
        end
        check("cnt_saturated", stall_cnt, {CW{1'b1}});
        nop2();

        // asynchronous reset mid-stream
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 1, 2'b01, 2'b00);
        #2 Rst = 1'b0;
        #1;
        check("async_ex_valid", ex_valid, 0);
        check("async_sel_a", fwd_sel_a, 0);
        check("async_sel_b", fwd_sel_b, 0);
        check("async_stall", stall, 0);
        check("async_cnt", stall_cnt, 0);
        exp_cnt = '0;
        id_valid = 0; id_reg_write = 0; id_mem_read = 0;
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1;
        drive(1, 3, 3, 1, 1, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        nop2();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
